// File: rtl/xcorr_pkg.sv
// rtl/xcorr_pkg.sv - shared engine states, width helpers and sample slicing for xcorr_lag
package xcorr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_MAC,
    ST_DRAIN,
    ST_CMP,
    ST_DONE
  } state_t;

  function automatic int lag_width(input int maxlag);
    return $clog2(maxlag + 1) + 1;
  endfunction

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Top dw bits of a 24-bit sample, right-aligned; the caller sizes the result to dw.
  function automatic logic [23:0] sample_top(input logic [23:0] data, input int dw);
    return data >> (24 - dw);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port sample RAM with a registered read port
module sample_ram #(
  parameter int DW     = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/xcorr_lag.sv
// rtl/xcorr_lag.sv - ping-pong framed cross-correlation peak-lag estimator
module xcorr_lag
  import xcorr_pkg::*;
#(
  parameter int N      = 256,
  parameter int MAXLAG = 16,
  parameter int DW     = 16,
  parameter int LW     = lag_width(MAXLAG),
  parameter int AW     = acc_width(DW, N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [23:0]   mic_data_left,
  input  logic [23:0]   mic_data_right,
  input  logic          finished_left,
  input  logic          finished_right,
  output logic [LW-1:0] lag_out,
  output logic [AW-1:0] peak_out,
  output logic          lag_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * DW;

  state_t state_q, state_d;

  logic [DW-1:0] held_l, held_r, pair_l, pair_r;
  logic          pend_l, pend_r, pair_we;
  logic          wr_bank, rd_bank, start_q, engine_busy;
  logic [IW-1:0] wr_idx;

  // A strobe arriving in the same cycle as the other channel's pending value completes the pair at once.
  assign pair_l      = finished_left  ? DW'(sample_top(mic_data_left,  DW)) : held_l;
  assign pair_r      = finished_right ? DW'(sample_top(mic_data_right, DW)) : held_r;
  assign pair_we     = (pend_l | finished_left) & (pend_r | finished_right);
  assign engine_busy = (state_q != ST_IDLE) | start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_l  <= '0;
      held_r  <= '0;
      pend_l  <= 1'b0;
      pend_r  <= 1'b0;
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      start_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      start_q <= 1'b0;
      if (pair_we) begin
        pend_l <= 1'b0;
        pend_r <= 1'b0;
        wr_idx <= wr_idx + IW'(1);
        if (wr_idx == IW'(N - 1)) begin
          if (engine_busy) begin
            overrun <= 1'b1;
          end else begin
            rd_bank <= wr_bank;
            wr_bank <= ~wr_bank;
            start_q <= 1'b1;
          end
        end
      end else begin
        if (finished_left) begin
          held_l <= pair_l;
          pend_l <= 1'b1;
        end
        if (finished_right) begin
          held_r <= pair_r;
          pend_r <= 1'b1;
        end
      end
    end
  end

  logic signed [IW:0]    k_q, best_lag;
  logic        [IW:0]    k_abs, cnt_q;
  logic        [IW-1:0]  n_q;
  logic        [1:0]     drain_q;
  logic                  rd_v, prod_v;
  logic        [DW-1:0]  rdata_l, rdata_r;
  logic signed [PW-1:0]  ext_l, ext_r, prod;
  logic signed [AW-1:0]  acc, best;

  assign k_abs = k_q[IW] ? (IW+1)'(-k_q) : (IW+1)'(k_q);
  assign ext_l = PW'($signed(rdata_l));
  assign ext_r = PW'($signed(rdata_r));

  sample_ram #(.DW(DW), .ADDR_W(IW + 1)) u_ram_l (
    .clk   (clk),
    .we    (pair_we),
    .waddr ({wr_bank, wr_idx}),
    .wdata (pair_l),
    .raddr ({rd_bank, n_q}),
    .rdata (rdata_l)
  );

  sample_ram #(.DW(DW), .ADDR_W(IW + 1)) u_ram_r (
    .clk   (clk),
    .we    (pair_we),
    .waddr ({wr_bank, wr_idx}),
    .wdata (pair_r),
    .raddr ({rd_bank, n_q + k_q[IW-1:0]}),
    .rdata (rdata_r)
  );

  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:  if (start_q) state_d = ST_INIT;
      ST_INIT:  state_d = ST_MAC;
      ST_MAC:   if (cnt_q == (IW+1)'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == 2'd2) state_d = ST_CMP;
      ST_CMP:   state_d = (k_q == (IW+1)'(MAXLAG)) ? ST_DONE : ST_INIT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      rd_v      <= 1'b0;
      prod_v    <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      best      <= '0;
      best_lag  <= '0;
      lag_out   <= '0;
      peak_out  <= '0;
      lag_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      lag_valid <= 1'b0;
      // Three-stage pipe: RAM read, product register, accumulate.
      rd_v      <= (state_q == ST_MAC);
      prod_v    <= rd_v;
      prod      <= ext_l * ext_r;
      if (prod_v) acc <= acc + AW'(prod);
      unique case (state_q)
        ST_IDLE: k_q <= (IW+1)'(-MAXLAG);
        ST_INIT: begin
          n_q     <= k_q[IW] ? k_abs[IW-1:0] : '0;
          cnt_q   <= (IW+1)'(N) - k_abs;
          drain_q <= '0;
          acc     <= '0;
        end
        ST_MAC: begin
          n_q   <= n_q + IW'(1);
          cnt_q <= cnt_q - (IW+1)'(1);
        end
        ST_DRAIN: drain_q <= drain_q + 2'd1;
        ST_CMP: begin
          // Strictly-greater keeps the most negative lag on ties.
          if (k_q == (IW+1)'(-MAXLAG) || acc > best) begin
            best     <= acc;
            best_lag <= k_q;
          end
          k_q <= k_q + (IW+1)'(1);
        end
        ST_DONE: begin
          lag_out   <= LW'(best_lag);
          peak_out  <= best;
          lag_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xcorr_lag.sv
// tb/tb_xcorr_lag.sv - table-driven scoreboard bench for xcorr_lag
module tb_xcorr_lag;

  localparam int N       = 256;
  localparam int MAXLAG  = 16;
  localparam int LAT     = 8343;
  localparam int MIN_GAP = LAT + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] mic_data_left, mic_data_right;
  logic        finished_left, finished_right;
  logic [5:0]  lag_out;
  logic [40:0] peak_out;
  logic        lag_valid, busy, overrun;

  always #5 clk = ~clk;

  xcorr_lag dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mic_data_left  (mic_data_left),
    .mic_data_right (mic_data_right),
    .finished_left  (finished_left),
    .finished_right (finished_right),
    .lag_out        (lag_out),
    .peak_out       (peak_out),
    .lag_valid      (lag_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  typedef struct { int lag; longint peak; int due; } exp_t;
  typedef struct { int kind; int d; int lag; longint peak; int mode; } vec_t;

  exp_t        exp_q[$];
  int          ovr_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          ovr_seen = 0;
  int          pidx = 0;
  int          last_acc = -100000;
  int          mode = 0;
  int          t_lag = 0;
  longint      t_peak = 0;
  int          mf_l[N];
  int          mf_r[N];
  logic [23:0] x[300];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int tr(input logic [23:0] v);
    logic signed [15:0] s;
    s = v[23:8];
    return int'(s);
  endfunction

  task automatic model(output int lag, output longint peak);
    longint s, bp;
    int bl;
    bp = 0;
    bl = 0;
    for (int k = -MAXLAG; k <= MAXLAG; k++) begin
      s = 0;
      for (int n = 0; n < N; n++)
        if (n + k >= 0 && n + k < N) s += longint'(mf_l[n]) * longint'(mf_r[n + k]);
      if (k == -MAXLAG || s > bp) begin
        bp = s;
        bl = k;
      end
    end
    lag = bl;
    peak = bp;
  endtask

  // Called at the negedge before the edge that writes the pair.
  task automatic record_pair(input int l, input int r);
    exp_t e;
    int a;
    mf_l[pidx] = l;
    mf_r[pidx] = r;
    if (pidx == N - 1) begin
      a = cyc + 1;
      if (a - last_acc >= MIN_GAP) begin
        model(e.lag, e.peak);
        if (mode >= 1) e.lag = t_lag;
        if (mode == 2) e.peak = t_peak;
        e.due = a + LAT;
        exp_q.push_back(e);
        last_acc = a;
      end else begin
        ovr_q.push_back(a);
      end
      pidx = 0;
    end else begin
      pidx++;
    end
  endtask

  task automatic drive(input logic fl, input logic fr, input logic [23:0] dl, input logic [23:0] dr);
    finished_left  = fl;
    finished_right = fr;
    mic_data_left  = dl;
    mic_data_right = dr;
    @(negedge clk);
    finished_left  = 1'b0;
    finished_right = 1'b0;
  endtask

  task automatic send_pair(input logic [23:0] dl, input logic [23:0] dr, input int gap);
    record_pair(tr(dl), tr(dr));
    drive(1'b1, 1'b1, dl, dr);
    repeat (gap) drive(1'b0, 1'b0, dl, dr);
  endtask

  task automatic fill_x();
    for (int i = 0; i < 300; i++) x[i] = 24'($urandom());
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ovr_q.size() != 0) && t < 12000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_results_seen"}, longint'(exp_q.size() + ovr_q.size()), 0);
    exp_q.delete();
    ovr_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      if (lag_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_lag_valid", lag_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("lag_out", $signed(lag_out), e.lag);
          chk("peak_out", $signed(peak_out), e.peak);
          chk("lag_valid_cycle", cyc, e.due);
        end
      end
      if (overrun) begin
        ovr_seen++;
        if (ovr_q.size() == 0) chk("spurious_overrun", overrun, 0);
        else chk("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: time limit reached, got %0d cycles", cyc);
    $display("%0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{0, 3, 3, 0, 1};
    vecs[1] = '{0, -5, -5, 0, 1};
    vecs[2] = '{1, 0, -16, 0, 2};
    vecs[3] = '{2, 0, 0, 64'd274861129984, 2};

    rst_n = 1'b0;
    finished_left = 1'b0;
    finished_right = 1'b0;
    mic_data_left = '0;
    mic_data_right = '0;
    repeat (3) @(negedge clk);
    chk("rst_lag_out", lag_out, 0);
    chk("rst_peak_out", peak_out, 0);
    chk("rst_lag_valid", lag_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      t_lag = vecs[v].lag;
      t_peak = vecs[v].peak;
      fill_x();
      for (int n = 0; n < N; n++) begin
        case (vecs[v].kind)
          0:       send_pair(x[n + 20], x[n + 20 - vecs[v].d], 0);
          1:       send_pair(24'h000000, 24'h000000, 0);
          default: send_pair(24'h7FFFFF, 24'h7FFFFF, 0);
        endcase
      end
      wait_idle($sformatf("vec%0d", v));
    end

    // Pairing: the second left overwrites the first before the right completes the pair.
    mode = 2;
    t_lag = 0;
    t_peak = 64'd33554432;
    drive(1'b1, 1'b0, 24'h0A0000, 24'h000000);
    drive(1'b1, 1'b0, 24'h100000, 24'h000000);
    record_pair(32'h1000, 32'h2000);
    drive(1'b0, 1'b1, 24'h000000, 24'h200000);
    for (int n = 1; n < N; n++) send_pair(24'h000000, 24'h000000, 0);
    wait_idle("pairing");

    // Overrun: frames every 1024 cycles; only the first and tenth are processed.
    mode = 0;
    ovr_seen = 0;
    for (int f = 0; f < 10; f++) begin
      fill_x();
      for (int n = 0; n < N; n++)
        send_pair(x[n + 20], x[n + 20 - ((f == 9) ? -7 : 2)], 3);
    end
    wait_idle("overrun");
    chk("overrun_pulses", ovr_seen, 8);

    // Reset mid-MAC with a partial next frame in flight.
    fill_x();
    for (int n = 0; n < N; n++) send_pair(x[n + 20], x[n + 16], 0);
    for (int n = 0; n < 100; n++) send_pair(x[n], x[n + 1], 0);
    chk("busy_mid_compute", busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    ovr_q.delete();
    pidx = 0;
    last_acc = -100000;
    #1;
    chk("midrst_lag_out", lag_out, 0);
    chk("midrst_peak_out", peak_out, 0);
    chk("midrst_lag_valid", lag_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    fill_x();
    for (int n = 0; n < N; n++) send_pair(x[n + 20], x[n + 22], 0);
    wait_idle("after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
